seq_booth_mul: RTL and testbench
================================

SEQ_BOOTH_MUL -- requirements
Module: seq_booth_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; even, >= 4.
REQ-002 SHALL have derived constant NITER = WIDTH/2 + 1, the number of radix-4 iterations.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request; accepted only in IDLE or DONE.
REQ-006 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
REQ-007 a  input  WIDTH  multiplicand; sampled at accept.
REQ-008 b  input  WIDTH  multiplier; sampled at accept.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; hi/lo valid.
REQ-011 hi  output  WIDTH  upper half of product.
REQ-012 lo  output  WIDTH  lower half of product.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE->RUN on start; DONE->RUN on start; DONE->IDLE otherwise; RUN->DONE after the NITER-th iteration.
REQ-015 On accept, a and b SHALL be latched as WIDTH+2 values, sign-extended if is_signed=1 and zero-extended otherwise, and the iteration counter SHALL be cleared.
REQ-016 Each RUN cycle SHALL retire one bit-pair, using Booth group {b[2i+1], b[2i], b[2i-1]} with b[-1]=0.
REQ-017 Group mapping SHALL be: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
REQ-018 The accumulator SHALL be wide enough that no intermediate overflows (>= 2*WIDTH+4 bits); the result is its low 2*WIDTH bits.
REQ-019 Latency: with start accepted at edge T0, done SHALL be 1 and hi/lo SHALL hold the result after edge T0+NITER (17 edges for WIDTH=32).
REQ-020 busy SHALL be 1 exactly in the NITER cycles between accept and done.
REQ-021 done SHALL be high for exactly one cycle per accepted start.
REQ-022 hi/lo SHALL update only on entry to DONE, and SHALL hold until the next completion or clr.
REQ-023 start during RUN SHALL be ignored: no restart, and latched operands unchanged.
REQ-024 start asserted in the DONE cycle SHALL be accepted (back-to-back): done=1 and busy goes 1 on the next edge.
REQ-025 Changes on a, b or is_signed after accept SHALL NOT affect the result.
REQ-026 The result SHALL be exact for all operand pairs, including the most-negative value in signed mode and all-ones in unsigned mode.

Reset
REQ-027 clr=1 at an edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and accumulator, regardless of state.
REQ-028 clr SHALL take priority over start at the same edge.
REQ-029 An operation aborted by clr SHALL produce no done pulse.

Structure
REQ-030 Shared package mul_pkg SHALL hold the FSM state enum and the Booth select encoding (ZERO, POS1, POS2, NEG1, NEG2).
REQ-031 Sub-module booth_enc_r4 SHALL be purely combinational: 3-bit group in, select out (mul_pkg encoding).
REQ-032 The datapath SHALL instantiate one booth_enc_r4 and one adder; no full partial-product array.

Verification
REQ-033 WIDTH=32, signed, a=-7 (FFFFFFF9), b=3 -> hi=FFFFFFFF, lo=FFFFFFEB; done 17 edges after accept.
REQ-034 WIDTH=32, a=b=FFFFFFFF: unsigned -> hi=FFFFFFFE, lo=00000001; signed -> hi=00000000, lo=00000001.
REQ-035 WIDTH=32, signed, a=b=80000000 -> hi=40000000, lo=00000000; signed 80000000*7FFFFFFF -> hi=C0000000, lo=80000000.
REQ-036 Control scenario, two requests issued back-to-back:
 - first request 5*6;
 - start pulsed mid-RUN, and a/b changed after accept: result 30 (lo=0000001E), busy stays high;
 - second start in the DONE cycle, 2*3: lo=00000006, 17 edges later.
REQ-037 clr asserted at iteration 8 -> outputs 0, IDLE, no done; a new 4*4 request then gives lo=00000010.
REQ-038 WIDTH=8, unsigned 255*255 -> {hi,lo}=FE01; signed 80*80 -> 4000; done 5 edges after accept.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mul_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 Booth partial-product select: multiple of the multiplicand to add.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } sel_t;

endpackage

// File: rtl/booth_enc_r4.sv
// Radix-4 Booth recoder: one overlapping 3-bit multiplier group -> partial-product select.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
//
// Ports:
//   grp - {b[2i+1], b[2i], b[2i-1]} multiplier group
//   sel - select in mul_pkg::sel_t encoding
module booth_enc_r4
    import mul_pkg::*;
(
    input  logic [2:0] grp,
    output sel_t       sel
);

    always_comb begin
        sel = ZERO;
        unique case (grp)
            3'b000, 3'b111: sel = ZERO;
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, one bit-pair retired per cycle.
// Latency: done pulses NITER (= WIDTH/2 + 1) edges after start is accepted.
// Backpressure: start is only accepted in IDLE or DONE; start while busy is ignored.
//
// Ports:
//   clk, clr         - clock, synchronous active-high clear
//   start, is_signed - request and operand signedness (sampled at accept)
//   a, b             - multiplicand and multiplier (sampled at accept)
//   busy, done       - operation in progress / one-cycle completion pulse
//   hi, lo           - upper and lower halves of the 2*WIDTH product
module seq_booth_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int NITER = WIDTH / 2 + 1;
    localparam int OW    = WIDTH + 2;        // extended operand width
    localparam int AW    = 2 * WIDTH + 4;    // accumulator width, never overflows
    localparam int CW    = $clog2(NITER + 1);

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   mcand;     // multiplicand, pre-shifted left by 2 each iteration
    logic [OW-1:0]   mplier;    // multiplier, shifted right by 2 each iteration
    logic            prev_bit;  // b[2i-1] of the current group

    logic            accept;
    logic            last_iter;
    logic [OW-1:0]   a_ext;
    logic [OW-1:0]   b_ext;
    sel_t            sel;
    logic [AW-1:0]   mag;
    logic [AW-1:0]   addend;
    logic            neg;
    logic [AW-1:0]   sum;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == RUN) && (cnt == CW'(NITER - 1));

    // Two extra bits make unsigned operands look like positive signed ones,
    // so a single signed Booth recoding covers both modes.
    assign a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    booth_enc_r4 u_enc (
        .grp ({mplier[1], mplier[0], prev_bit}),
        .sel (sel)
    );

    // Single adder: negative selects add the one's complement with carry-in 1.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        unique case (sel)
            POS1:    mag = mcand;
            POS2:    mag = mcand << 1;
            NEG1:    begin mag = mcand;      neg = 1'b1; end
            NEG2:    begin mag = mcand << 1; neg = 1'b1; end
            default: mag = '0;
        endcase
    end

    assign addend = neg ? ~mag : mag;
    assign sum    = acc + addend + {{(AW-1){1'b0}}, neg};

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prev_bit <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= {{(AW-OW){a_ext[OW-1]}}, a_ext};
            mplier   <= b_ext;
            prev_bit <= 1'b0;
        end else if (state == RUN) begin
            cnt      <= cnt + 1'b1;
            acc      <= sum;
            mcand    <= mcand << 2;
            mplier   <= {2'b00, mplier[OW-1:2]};
            prev_bit <= mplier[1];
            if (last_iter) begin
                hi <= sum[2*WIDTH-1:WIDTH];
                lo <= sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_booth_mul.sv
// Self-checking bench for seq_booth_mul (WIDTH=32 and WIDTH=8 instances).
// Latency: checks done arrives exactly NITER edges after accept.
// Backpressure: exercises start during RUN and back-to-back start in DONE.
module tb_seq_booth_mul;

    logic        clk;
    logic        clr;
    logic        start, is_signed;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int n_checks;
    int n_fail;

    seq_booth_mul #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    seq_booth_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend to double width, multiply, keep low half.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] xe, ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    function automatic logic [15:0] ref_mul8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [15:0] xe, ye;
        xe = s ? {{8{x[7]}}, x} : {8'b0, x};
        ye = s ? {{8{y[7]}}, y} : {8'b0, y};
        return xe * ye;
    endfunction

    function automatic logic [31:0] pick_operand();
        int r;
        r = $urandom_range(0, 6);
        case (r)
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request on the 32-bit instance, scramble inputs after accept,
    // and wait (bounded) for done. lat counts edges after the accept edge.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          output int lat, output logic busy_ok,
                          output logic [31:0] rh, output logic [31:0] rl);
        @(negedge clk);
        a = x; b = y; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
        lat = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        rh = hi;
        rl = lo;
    endtask

    task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                           output int lat, output logic [15:0] prod);
        @(negedge clk);
        a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        prod = {hi8, lo8};
    endtask

    task automatic test_reset();
        // clr and start together: clr must win.
        clr = 1'b1; start = 1'b1; start8 = 1'b1;
        a = 32'd3; b = 32'd3; a8 = 8'd3; b8 = 8'd3;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
        end
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: hi=%h lo=%h, required 0 0", hi, lo);
        end
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || hi8 !== 8'h0 || lo8 !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_w8: busy=%b done=%b hi=%h lo=%h, required all 0", busy8, done8, hi8, lo8);
        end
        clr = 1'b0; start = 1'b0; start8 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vs [5];
        logic [31:0] eh [5];
        logic [31:0] el [5];
        int          lat;
        logic        bok;
        logic [31:0] rh, rl;
        va[0] = 32'hFFFF_FFF9; vb[0] = 32'h3;          vs[0] = 1'b1; eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFEB;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;  vs[1] = 1'b0; eh[1] = 32'hFFFF_FFFE; el[1] = 32'h0000_0001;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;  vs[2] = 1'b1; eh[2] = 32'h0000_0000; el[2] = 32'h0000_0001;
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000;  vs[3] = 1'b1; eh[3] = 32'h4000_0000; el[3] = 32'h0000_0000;
        va[4] = 32'h8000_0000; vb[4] = 32'h7FFF_FFFF;  vs[4] = 1'b1; eh[4] = 32'hC000_0000; el[4] = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vs[i], lat, bok, rh, rl);
            n_checks++;
            if (lat != 17) begin
                n_fail++;
                $display("FAIL dir%0d_latency: %0d edges, required 17", i, lat);
            end
            n_checks++;
            if (!bok || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_busy: busy_ok=%b busy_at_done=%b, required 1 0", i, bok, busy);
            end
            n_checks++;
            if (rh !== eh[i] || rl !== el[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: %h_%h, required %h_%h", i, rh, rl, eh[i], el[i]);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || hi !== eh[i] || lo !== el[i]) begin
                n_fail++;
                $display("FAIL dir%0d_hold: done=%b %h_%h, required 0 %h_%h", i, done, hi, lo, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic        bok;
        logic [31:0] rh, rl, x, y;
        logic        s;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            x = pick_operand();
            y = pick_operand();
            s = 1'($urandom_range(0, 1));
            exp = ref_mul(x, y, s);
            run_op(x, y, s, lat, bok, rh, rl);
            n_checks++;
            if ({rh, rl} !== exp || lat != 17 || !bok) begin
                n_fail++;
                $display("FAIL rand%0d: %h*%h s=%b got %h_%h lat=%0d busy_ok=%b, required %h lat=17",
                         i, x, y, s, rh, rl, lat, bok, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 32'd5; b = 32'd6; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'b1;
        lat = 0;
        repeat (4) begin @(negedge clk); lat++; end
        // Start mid-RUN with different operands: must be ignored.
        start = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk); lat++;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_midrun_busy: busy=%b done=%b, required 1 0", busy, done);
        end
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 17 || hi !== 32'h0 || lo !== 32'h0000_001E) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d %h_%h, required 17 00000000_0000001e", lat, hi, lo);
        end
        // Second request in the DONE cycle.
        a = 32'd2; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        n_checks++;
        if (lo !== 32'h0000_001E) begin
            n_fail++;
            $display("FAIL b2b_hold_during_run: lo=%h, required 0000001e", lo);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 17 || hi !== 32'h0 || lo !== 32'h0000_0006) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d %h_%h, required 17 00000000_00000006", lat, hi, lo);
        end
    endtask

    task automatic test_clr_abort();
        int          lat;
        logic        bok;
        logic        seen;
        logic [31:0] rh, rl;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; is_signed = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pre_busy: busy=%b, required 1", busy);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_abort_state: busy=%b done=%b %h_%h, required 0 0 0_0", busy, done, hi, lo);
        end
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_no_done: activity seen=%b, required 0", seen);
        end
        run_op(32'd4, 32'd4, 1'b0, lat, bok, rh, rl);
        n_checks++;
        if (lat != 17 || rh !== 32'h0 || rl !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL clr_restart: lat=%0d %h_%h, required 17 00000000_00000010", lat, rh, rl);
        end
    endtask

    task automatic test_width8();
        int          lat;
        logic [15:0] p, exp;
        logic [7:0]  x, y;
        logic        s;
        run_op8(8'hFF, 8'hFF, 1'b0, lat, p);
        n_checks++;
        if (lat != 5 || p !== 16'hFE01) begin
            n_fail++;
            $display("FAIL w8_unsigned_ff: lat=%0d prod=%h, required 5 fe01", lat, p);
        end
        run_op8(8'h80, 8'h80, 1'b1, lat, p);
        n_checks++;
        if (lat != 5 || p !== 16'h4000) begin
            n_fail++;
            $display("FAIL w8_signed_80: lat=%0d prod=%h, required 5 4000", lat, p);
        end
        for (int i = 0; i < 30; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            exp = ref_mul8(x, y, s);
            run_op8(x, y, s, lat, p);
            n_checks++;
            if (lat != 5 || p !== exp) begin
                n_fail++;
                $display("FAIL w8_rand%0d: %h*%h s=%b lat=%0d prod=%h, required 5 %h", i, x, y, s, lat, p, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clr_abort();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
